// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding,
// default sizes and a helper used to size the fill counter.
package seq_det_pkg;

  // FSM encoding; 2'd3 is never entered on purpose and recovers to S_FILL.
  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_ARMED   = 2'd1,
    S_MATCH   = 2'd2,
    S_ILLEGAL = 2'd3
  } det_state_e;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Bits needed to hold a fill level from 0 up to and including pat_w.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Bus between the bit-stream source / pattern controller and the detector.
// The master drives the stream and control; the slave (detector) drives
// the match pulse, counter and armed flag.
interface seq_pattern_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in_vld;
  logic             in_bit;
  logic             pat_load;
  logic [PAT_W-1:0] pat;
  logic             cnt_clr;
  logic             det;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output in_vld, in_bit, pat_load, pat, cnt_clr,
    input  det, match_cnt, armed
  );

  modport slave (
    input  in_vld, in_bit, pat_load, pat, cnt_clr,
    output det, match_cnt, armed
  );
endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter. A clear that coincides with an increment
// lands on 1 so the coincident event is still counted.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_ZERO = W'(0);
  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_n;

  // Next count: clear wins over hold, increment stops at all-ones.
  always_comb begin
    w_cnt_n = r_cnt;
    if (clr) begin
      w_cnt_n = inc ? CNT_ONE : CNT_ZERO;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      w_cnt_n = r_cnt + CNT_ONE;
    end else begin
      w_cnt_n = r_cnt;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= w_cnt_n;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised Moore serial-pattern detector with run-time pattern reload,
// optional overlapping matches, input qualifier, registered match pulse
// and saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1010,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rstn,
  seq_pattern_detector_if.slave bus
);

  localparam int               FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ZERO = FILL_W'(0);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  // Only the last PAT_W-1 bits are kept; the incoming bit completes the
  // PAT_W-bit window, so the oldest stored bit is never needed.
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pat_q;
  det_state_e        r_state;
  logic              r_det;
  logic              r_armed;

  logic [PAT_W-1:0]  w_hist_n;
  logic [FILL_W-1:0] w_fill_n;
  logic              w_hit;
  logic [PAT_W-2:0]  w_hist_d;
  logic [FILL_W-1:0] w_fill_d;
  det_state_e        w_state_n;
  logic [CNT_W-1:0]  w_cnt;

  // Candidate window and fill level if the current bit is accepted.
  always_comb begin
    w_hist_n = {r_hist, bus.in_bit};
    if (r_fill == FILL_FULL) begin
      w_fill_n = r_fill;
    end else begin
      w_fill_n = r_fill + FILL_ONE;
    end
    w_hit = bus.in_vld && (w_fill_n == FILL_FULL) && (w_hist_n == r_pat_q);
  end

  // Next history, fill and state; a pattern reload discards the bit.
  always_comb begin
    w_hist_d  = r_hist;
    w_fill_d  = r_fill;
    w_state_n = r_state;
    if (bus.pat_load) begin
      w_hist_d  = {(PAT_W-1){1'b0}};
      w_fill_d  = FILL_ZERO;
      w_state_n = S_FILL;
    end else begin
      if (bus.in_vld) begin
        w_hist_d = w_hist_n[PAT_W-2:0];
        // Without overlap a hit consumes the window: PAT_W fresh bits needed.
        w_fill_d = (w_hit && !OVERLAP) ? FILL_ZERO : w_fill_n;
      end else begin
        w_hist_d = r_hist;
        w_fill_d = r_fill;
      end
      case (r_state)
        S_FILL: begin
          if (w_hit) begin
            w_state_n = S_MATCH;
          end else if (bus.in_vld && (w_fill_n == FILL_FULL)) begin
            w_state_n = S_ARMED;
          end else begin
            w_state_n = S_FILL;
          end
        end
        S_ARMED: begin
          w_state_n = w_hit ? S_MATCH : S_ARMED;
        end
        S_MATCH: begin
          if (OVERLAP) begin
            w_state_n = w_hit ? S_MATCH : S_ARMED;
          end else begin
            w_state_n = S_FILL;
          end
        end
        default: begin
          w_state_n = S_FILL;
        end
      endcase
    end
  end

  // State, history, pattern and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist  <= {(PAT_W-1){1'b0}};
      r_fill  <= FILL_ZERO;
      r_pat_q <= PAT_RST;
      r_state <= S_FILL;
      r_det   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_hist  <= w_hist_d;
      r_fill  <= w_fill_d;
      r_pat_q <= bus.pat_load ? bus.pat : r_pat_q;
      r_state <= w_state_n;
      r_det   <= (r_state == S_MATCH);
      r_armed <= (w_state_n != S_FILL);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (r_state == S_MATCH),
    .clr  (bus.cnt_clr),
    .cnt  (w_cnt)
  );

  assign bus.det       = r_det;
  assign bus.armed     = r_armed;
  assign bus.match_cnt = w_cnt;

endmodule
